// File: rtl/smc_pwm_core.sv
// Multi-channel H-bridge PWM controller: Q-bus register file, shared period counter,
// per-channel left/right/center-aligned PWM with duty double-buffered at period wrap.
module smc_pwm_core #(
  parameter int unsigned NUM_CH = 12,
  parameter int unsigned PER_W  = 11,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              QCLK,
  input  logic              QRESET,
  input  logic              QSEL,
  input  logic              QWRITE,
  input  logic [ADDR_W-1:0] QADDR,
  input  logic [15:0]       QDATAIN,
  output logic [15:0]       QDATAOUT,
  output logic [NUM_CH-1:0] MNP,
  output logic [NUM_CH-1:0] MNM
);

  localparam int unsigned CC_BASE = 2;
  localparam int unsigned DC_BASE = 2 + NUM_CH;

  logic             en;
  logic [PER_W-1:0] per;
  logic [PER_W-1:0] cnt;

  logic [1:0]       sh_mode    [NUM_CH];
  logic [1:0]       sh_mode_n  [NUM_CH];
  logic [1:0]       act_mode   [NUM_CH];
  logic [PER_W-1:0] sh_duty    [NUM_CH];
  logic [PER_W-1:0] sh_duty_n  [NUM_CH];
  logic [PER_W-1:0] act_duty   [NUM_CH];
  logic [NUM_CH-1:0] sh_sign, sh_sign_n, act_sign;

  logic              wr;
  logic              run;
  logic              wrap;
  logic              load;
  logic [NUM_CH-1:0] pwm;
  logic [PER_W:0]    d_eff, c_ext, c_dbl, p_ext;
  logic              unused_data;

  assign wr          = QSEL & QWRITE;
  assign run         = en && (per != '0);
  assign wrap        = run && (cnt >= per - PER_W'(1));
  assign load        = !run || wrap;
  assign unused_data = ^QDATAIN;

  // Next shadow values; a write coinciding with a load is forwarded into it
  always_comb begin
    sh_mode_n = sh_mode;
    sh_duty_n = sh_duty;
    sh_sign_n = sh_sign;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (wr && QADDR == ADDR_W'(CC_BASE + ch))
        sh_mode_n[ch] = QDATAIN[1:0];
      if (wr && QADDR == ADDR_W'(DC_BASE + ch)) begin
        sh_duty_n[ch] = QDATAIN[PER_W-1:0];
        sh_sign_n[ch] = QDATAIN[15];
      end
    end
  end

  // Per-channel compare against the effective (saturated) duty
  always_comb begin
    pwm   = '0;
    d_eff = '0;
    c_ext = {1'b0, cnt};
    c_dbl = {cnt, 1'b0};
    p_ext = {1'b0, per};
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      d_eff = (act_duty[ch] > per) ? p_ext : {1'b0, act_duty[ch]};
      case (act_mode[ch])
        2'b01:   pwm[ch] = c_ext < d_eff;
        2'b10:   pwm[ch] = c_ext >= p_ext - d_eff;
        2'b11:   pwm[ch] = (c_dbl >= p_ext - d_eff) && (c_dbl < p_ext + d_eff);
        default: pwm[ch] = 1'b0;
      endcase
    end
    if (!run)
      pwm = '0;
  end

  always_ff @(posedge QCLK or negedge QRESET) begin
    if (!QRESET) begin
      en       <= 1'b0;
      per      <= '0;
      cnt      <= '0;
      sh_sign  <= '0;
      act_sign <= '0;
      MNP      <= '0;
      MNM      <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        sh_mode[ch]  <= '0;
        act_mode[ch] <= '0;
        sh_duty[ch]  <= '0;
        act_duty[ch] <= '0;
      end
    end else begin
      if (wr && QADDR == ADDR_W'(0))
        en <= QDATAIN[0];
      if (wr && QADDR == ADDR_W'(1))
        per <= QDATAIN[PER_W-1:0];
      sh_mode <= sh_mode_n;
      sh_duty <= sh_duty_n;
      sh_sign <= sh_sign_n;
      if (load) begin
        act_mode <= sh_mode_n;
        act_duty <= sh_duty_n;
        act_sign <= sh_sign_n;
      end
      if (!run || wrap)
        cnt <= '0;
      else
        cnt <= cnt + PER_W'(1);
      MNP <= pwm & ~act_sign;
      MNM <= pwm & act_sign;
    end
  end

  // Combinational read mux; unmapped or deselected reads return 0
  always_comb begin
    QDATAOUT = '0;
    if (QSEL && !QWRITE) begin
      if (QADDR == ADDR_W'(0))
        QDATAOUT[0] = en;
      if (QADDR == ADDR_W'(1))
        QDATAOUT[PER_W-1:0] = per;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (QADDR == ADDR_W'(CC_BASE + ch))
          QDATAOUT[1:0] = sh_mode[ch];
        if (QADDR == ADDR_W'(DC_BASE + ch)) begin
          QDATAOUT[15]         = sh_sign[ch];
          QDATAOUT[PER_W-1:0]  = sh_duty[ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_smc_pwm_core.sv
// Randomized bench for smc_pwm_core against an integer-arithmetic reference model.
module tb_smc_pwm_core;

  localparam int NCH   = 12;
  localparam int PW    = 11;
  localparam int AW    = 7;
  localparam int PMASK = (1 << PW) - 1;
  localparam int NREG  = 2 + 2 * NCH;

  logic           QCLK = 1'b0;
  logic           QRESET;
  logic           QSEL;
  logic           QWRITE;
  logic [AW-1:0]  QADDR;
  logic [15:0]    QDATAIN;
  logic [15:0]    QDATAOUT;
  logic [NCH-1:0] MNP;
  logic [NCH-1:0] MNM;

  smc_pwm_core #(.NUM_CH(NCH), .PER_W(PW), .ADDR_W(AW)) dut (
    .QCLK(QCLK), .QRESET(QRESET), .QSEL(QSEL), .QWRITE(QWRITE), .QADDR(QADDR),
    .QDATAIN(QDATAIN), .QDATAOUT(QDATAOUT), .MNP(MNP), .MNM(MNM)
  );

  always #5 QCLK = ~QCLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: register file, shadow/active duty, counter as plain integers
  int m_en, m_per, m_cnt;
  int m_mode[NCH], m_duty[NCH], m_sign[NCH];
  int a_mode[NCH], a_duty[NCH], a_sign[NCH];
  logic [NCH-1:0] exp_p, exp_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_en = 0; m_per = 0; m_cnt = 0; exp_p = '0; exp_m = '0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_duty[c] = 0; m_sign[c] = 0;
      a_mode[c] = 0; a_duty[c] = 0; a_sign[c] = 0;
    end
  endtask

  function automatic int model_read(input int a);
    if (a == 0) return m_en;
    if (a == 1) return m_per;
    if (a >= 2 && a < 2 + NCH) return m_mode[a-2];
    if (a >= 2 + NCH && a < NREG) return (m_sign[a-2-NCH] << 15) | m_duty[a-2-NCH];
    return 0;
  endfunction

  task automatic model_edge();
    bit run, wrapped, on;
    int d, a, dat;
    run     = (m_en != 0) && (m_per != 0);
    wrapped = run && (m_cnt >= m_per - 1);
    for (int c = 0; c < NCH; c++) begin
      on = 0;
      if (run) begin
        d = (a_duty[c] < m_per) ? a_duty[c] : m_per;
        case (a_mode[c])
          1: on = m_cnt < d;
          2: on = m_cnt >= m_per - d;
          3: on = (2 * m_cnt >= m_per - d) && (2 * m_cnt < m_per + d);
          default: on = 0;
        endcase
      end
      exp_p[c] = on && (a_sign[c] == 0);
      exp_m[c] = on && (a_sign[c] != 0);
    end
    if (run && !wrapped) m_cnt = m_cnt + 1;
    else m_cnt = 0;
    if (QSEL && QWRITE) begin
      a = int'(QADDR); dat = int'(QDATAIN);
      if (a == 0) m_en = dat & 1;
      else if (a == 1) m_per = dat & PMASK;
      else if (a < 2 + NCH) m_mode[a-2] = dat & 3;
      else if (a < NREG) begin
        m_duty[a-2-NCH] = dat & PMASK;
        m_sign[a-2-NCH] = (dat >> 15) & 1;
      end
    end
    if (!run || wrapped)
      for (int c = 0; c < NCH; c++) begin
        a_mode[c] = m_mode[c]; a_duty[c] = m_duty[c]; a_sign[c] = m_sign[c];
      end
  endtask

  task automatic tick();
    @(posedge QCLK);
    if (!QRESET) model_reset();
    else model_edge();
    #1;
    check("mnp", MNP, exp_p);
    check("mnm", MNM, exp_m);
  endtask

  task automatic wr(input int a, input int dat);
    QSEL = 1'b1; QWRITE = 1'b1; QADDR = AW'(a); QDATAIN = 16'(dat);
    tick();
    QSEL = 1'b0; QWRITE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a);
    QSEL = 1'b1; QWRITE = 1'b0; QADDR = AW'(a);
    #1;
    check(tag, QDATAOUT, model_read(a));
    QSEL = 1'b0;
  endtask

  task automatic count_hi(input int ch, input bit neg, output int n);
    n = 0;
    repeat (10) begin
      tick();
      n += neg ? int'(MNM[ch]) : int'(MNP[ch]);
    end
  endtask

  int n, r, ch;

  initial begin
    QRESET = 1'b0; QSEL = 1'b0; QWRITE = 1'b0; QADDR = '0; QDATAIN = '0;
    model_reset();
    repeat (3) tick();
    QRESET = 1'b1;
    tick();
    for (int a = 0; a < NREG; a++) rd_chk("rst_reg", a);

    // Left-aligned 3/10
    wr(1, 10); wr(2, 1); wr(2 + NCH, 3); wr(0, 1);
    repeat (5) tick();
    count_hi(0, 0, n); check("left_hi", n, 3);
    count_hi(0, 1, n); check("left_mnm", n, 0);

    // Right 3/10, center 4/10, saturated 12/10
    wr(2, 2); repeat (12) tick();
    count_hi(0, 0, n); check("right_hi", n, 3);
    wr(2, 3); wr(2 + NCH, 4); repeat (12) tick();
    count_hi(0, 0, n); check("center_hi", n, 4);
    wr(2 + NCH, 12); repeat (12) tick();
    count_hi(0, 0, n); check("sat_hi", n, 10);

    // Double buffer: change duty mid-period
    wr(2, 1); wr(2 + NCH, 3); repeat (12) tick();
    for (int i = 0; i < 20 && m_cnt != 4; i++) tick();
    if (m_cnt != 4) check("cnt_wait", m_cnt, 4);
    wr(2 + NCH, 6);
    repeat (20) tick();
    wr(2 + NCH, 16'h8003); repeat (12) tick();
    count_hi(0, 1, n); check("neg_mnm", n, 3);
    count_hi(0, 0, n); check("neg_mnp", n, 0);

    // Edge cases
    wr(1, 0); repeat (12) tick();
    check("per0_pins", MNP | MNM, 0);
    wr(1, 10); wr(0, 0); repeat (12) tick();
    check("en0_pins", MNP | MNM, 0);
    rd_chk("unmapped", 16'h7F);
    QSEL = 1'b0; QWRITE = 1'b0; QADDR = AW'(1); #1;
    check("nosel_rd", QDATAOUT, 0);
    wr(0, 16'hFFFF);
    QSEL = 1'b1; QWRITE = 1'b0; QADDR = AW'(0); #1;
    check("ctl_rsvd", QDATAOUT, 16'h0001);
    QSEL = 1'b0;

    // Async reset with all pins driven
    for (int c = 0; c < NCH; c++) begin
      wr(2 + c, 1); wr(2 + NCH + c, ((c & 1) << 15) | 20);
    end
    repeat (12) tick();
    check("pre_rst_pins", MNP | MNM, {NCH{1'b1}});
    #2 QRESET = 1'b0;
    #1;
    check("async_mnp", MNP, 0);
    check("async_mnm", MNM, 0);
    tick();
    QRESET = 1'b1;
    tick();
    for (int a = 0; a < NREG; a++) rd_chk("rst2_reg", a);
    wr(1, 10);
    repeat (5) tick();

    // Randomized concurrent operation of all channels
    wr(1, $urandom_range(8, 40));
    for (int c = 0; c < NCH; c++) begin
      wr(2 + c, $urandom);
      wr(2 + NCH + c, ($urandom & 16'hF800) | $urandom_range(0, 45));
    end
    wr(0, 1);
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      ch = $urandom_range(0, NCH - 1);
      if (r < 8) wr(2 + NCH + ch, ($urandom & 16'hF800) | $urandom_range(0, 45));
      else if (r < 12) wr(2 + ch, $urandom);
      else if (r < 13) wr(1, ($urandom & 16'hF800) | $urandom_range(0, 40));
      else if (r < 14) wr(0, ($urandom & 16'hFFFE) | int'($urandom_range(0, 3) != 0));
      else if (r < 18) begin
        rd_chk("rand_rd", $urandom_range(0, 40));
        tick();
      end else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
